// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared constants for the EX-stage ALU control and the M-extension
// sequencer: ALUSel encodings, ALUop classes, M-op funct3 codes and the
// sequencer state type.
package alu_ctrl_pkg;

  // ALU operation select encodings driven onto the EX datapath
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_XOR    = 4'b0011;
  localparam logic [3:0] ALU_SLT    = 4'b0100;
  localparam logic [3:0] ALU_SLTU   = 4'b0101;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SRL    = 4'b0111;
  localparam logic [3:0] ALU_SRA    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b1001;
  localparam logic [3:0] ALU_MULDIV = 4'b1111;

  // Instruction class presented by the main decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_R      = 2'b10;
  localparam logic [1:0] ALUOP_I      = 2'b11;

  // funct7 value that marks an R-type instruction as an M-extension op
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // M-extension funct3 codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core
// Iterative RV32M datapath: one shift-add multiply step or one restoring
// divide step per cycle on magnitudes, with sign correction at the end.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_start               M-op issue request (already qualified by valid/flush)
//   i_flush               abandon the operation in flight
//   i_funct3              M-op selector
//   i_operand_a/b         rs1/rs2 values, sampled only at issue
//   o_result              final result, valid while o_done
//   o_done                one-cycle completion pulse
//   o_state               sequencer state, used for the stall handshake
module muldiv_core
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_flush,
  input  logic [2:0]          i_funct3,
  input  logic [XLEN-1:0]     i_operand_a,
  input  logic [XLEN-1:0]     i_operand_b,
  output logic [XLEN-1:0]     o_result,
  output logic                o_done,
  output muldiv_state_t       o_state
);

  localparam int CW = $clog2(XLEN);
  // XLEN is a power of two, so the last iteration index is all ones
  localparam logic [CW-1:0]   LAST_ITER = {CW{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     r_state;
  logic [CW-1:0]     r_count;
  logic [2*XLEN-1:0] r_work;
  logic [XLEN-1:0]   r_opb;
  logic [2:0]        r_funct3;
  logic              r_negQ;
  logic              r_negR;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  // Issue-time operand conditioning: signedness per op, magnitudes and
  // the divide corner cases that finish without iterating
  logic            w_isDiv, w_signedA, w_signedB, w_negA, w_negB;
  logic [XLEN-1:0] w_magA, w_magB;
  logic            w_divZero, w_ovf, w_special;
  logic [XLEN-1:0] w_specialResult;

  assign w_isDiv   = i_funct3[2];
  assign w_signedA = w_isDiv ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
  assign w_signedB = w_isDiv ? ~i_funct3[0] : ~i_funct3[1];
  assign w_negA    = w_signedA & i_operand_a[XLEN-1];
  assign w_negB    = w_signedB & i_operand_b[XLEN-1];
  assign w_magA    = w_negA ? -i_operand_a : i_operand_a;
  assign w_magB    = w_negB ? -i_operand_b : i_operand_b;
  assign w_divZero = w_isDiv & (i_operand_b == '0);
  assign w_ovf     = w_isDiv & ~i_funct3[0] & (i_operand_a == MOST_NEG) &
                     (i_operand_b == '1);
  assign w_special = w_divZero | w_ovf;
  // funct3[1] separates remainder ops from quotient ops
  assign w_specialResult = w_divZero ? (i_funct3[1] ? i_operand_a : '1)
                                     : (i_funct3[1] ? '0 : MOST_NEG);

  // One iteration of each algorithm. Multiply keeps the multiplier in the
  // low half and accumulates into the high half while shifting right.
  // Divide shifts the dividend left into a partial remainder in the high
  // half and shifts quotient bits in from the bottom.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mulNext;
  logic [XLEN:0]     w_remShift;
  logic [XLEN-1:0]   w_diff;
  logic              w_fits;
  logic [2*XLEN-1:0] w_divNext;
  logic [2*XLEN-1:0] w_workNext;

  assign w_sum      = {1'b0, r_work[2*XLEN-1:XLEN]} + {1'b0, r_opb};
  assign w_mulNext  = r_work[0] ? {w_sum, r_work[XLEN-1:1]}
                                : {1'b0, r_work[2*XLEN-1:1]};
  assign w_remShift = r_work[2*XLEN-1:XLEN-1];
  assign w_fits     = (w_remShift >= {1'b0, r_opb});
  // The true difference is below the divisor, so the low XLEN bits suffice
  assign w_diff     = w_remShift[XLEN-1:0] - r_opb;
  assign w_divNext  = w_fits ? {w_diff, r_work[XLEN-2:0], 1'b1}
                             : {r_work[2*XLEN-2:0], 1'b0};
  assign w_workNext = r_funct3[2] ? w_divNext : w_mulNext;

  // Sign correction applied to the final iteration's value
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_final;

  assign w_prod = r_negQ ? -w_workNext : w_workNext;
  assign w_quot = r_negQ ? -w_workNext[XLEN-1:0] : w_workNext[XLEN-1:0];
  assign w_rem  = r_negR ? -w_workNext[2*XLEN-1:XLEN]
                         : w_workNext[2*XLEN-1:XLEN];

  // Pick the half/part of the corrected value that the M-op asks for
  always_comb begin
    w_final = w_quot;
    case (r_funct3)
      F3_MUL:                       w_final = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_final = w_quot;
      F3_REM, F3_REMU:              w_final = w_rem;
      default:                      w_final = w_quot;
    endcase
  end

  // Sequencer: latch at issue, iterate XLEN times, publish the result for
  // exactly one DONE cycle. A flush abandons the operation without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_work   <= '0;
      r_opb    <= '0;
      r_funct3 <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_work   <= {{XLEN{1'b0}}, w_magA};
            r_opb    <= w_magB;
            r_funct3 <= i_funct3;
            r_negQ   <= w_negA ^ w_negB;
            r_negR   <= w_negA;
            r_count  <= '0;
            if (w_special) begin
              r_result <= w_specialResult;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_work  <= w_workNext;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_ITER) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_done   = r_done;
  assign o_state  = r_state;

endmodule

// File: rtl/alu_control_muldiv.sv
// alu_control_muldiv
// EX-stage ALU control: decodes ALUop/funct3/funct7 into ALUSel, detects
// M-extension ops and holds the pipeline while muldiv_core works on them.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_funct3, i_funct7    instruction[14:12], instruction[31:25]
//   i_ALUop               00 mem/jalr, 01 branch, 10 R-type, 11 I-type
//   i_ex_valid, i_flush   EX instruction valid / kill
//   i_operand_a/b         rs1/rs2 values
//   o_ALUSel              combinational ALU operation select
//   o_muldiv_result       M-op result, valid while o_muldiv_done
//   o_muldiv_done         one-cycle result-valid pulse
//   o_stall               hold IF/ID/EX while an M-op is in progress
module alu_control_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic [1:0]      i_ALUop,
  input  logic            i_ex_valid,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic [3:0]      o_ALUSel,
  output logic [XLEN-1:0] o_muldiv_result,
  output logic            o_muldiv_done,
  output logic            o_stall
);

  logic          w_mOp;
  logic          w_start;
  muldiv_state_t w_state;

  assign w_mOp   = ENABLE_M && (i_ALUop == ALUOP_R) && (i_funct7 == F7_MULDIV);
  assign w_start = w_mOp & i_ex_valid & ~i_flush;

  // ALUSel decode. R and I types share the funct3 map; only R-type uses
  // funct7[5] to select SUB, while both use it to select SRA.
  always_comb begin
    o_ALUSel = ALU_ADD;
    case (i_ALUop)
      ALUOP_MEM:    o_ALUSel = ALU_ADD;
      ALUOP_BRANCH: o_ALUSel = ALU_SUB;
      ALUOP_R, ALUOP_I: begin
        case (i_funct3)
          3'b000: o_ALUSel = ((i_ALUop == ALUOP_R) && i_funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: o_ALUSel = ALU_SLL;
          3'b010: o_ALUSel = ALU_SLT;
          3'b011: o_ALUSel = ALU_SLTU;
          3'b100: o_ALUSel = ALU_XOR;
          3'b101: o_ALUSel = i_funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: o_ALUSel = ALU_OR;
          3'b111: o_ALUSel = ALU_AND;
          default: o_ALUSel = ALU_ADD;
        endcase
        if (w_mOp) o_ALUSel = ALU_MULDIV;
      end
      default: o_ALUSel = ALU_ADD;
    endcase
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_flush     (i_flush),
    .i_funct3    (i_funct3),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .o_result    (o_muldiv_result),
    .o_done      (o_muldiv_done),
    .o_state     (w_state)
  );

  // Stall releases in DONE so the pipeline moves on as the result lands.
  // Reset also forces it low so the pipeline is never held under reset.
  assign o_stall = w_start & (w_state != S_DONE) & ~rst;

endmodule

// File: tb/tb_alu_control_muldiv.sv
module tb_alu_control_muldiv;

  logic        clk;
  logic        rst;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  aluOp;
  logic        exValid;
  logic        flush;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [3:0]  aluSel;
  logic [31:0] mdResult;
  logic        mdDone;
  logic        stall;

  int nChecks = 0;
  int nBad    = 0;
  int cycle   = 0;

  // Reference model state for the one operation in flight
  logic        mdActive = 1'b0;
  int          mdDoneCycle = 0;
  logic [31:0] mdExp = '0;
  logic        expDone, expStall;

  alu_control_muldiv #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_funct3        (funct3),
    .i_funct7        (funct7),
    .i_ALUop         (aluOp),
    .i_ex_valid      (exValid),
    .i_flush         (flush),
    .i_operand_a     (opA),
    .i_operand_b     (opB),
    .o_ALUSel        (aluSel),
    .o_muldiv_result (mdResult),
    .o_muldiv_done   (mdDone),
    .o_stall         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Reference: ALU select from the instruction-class rules
  function automatic logic [3:0] modelAluSel(input logic [1:0] op,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
    logic [3:0] tbl [8];
    if (op == 2'b10 && f7 == 7'b0000001) return 4'b1111;
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    tbl[0] = 4'b0010; tbl[1] = 4'b1001; tbl[2] = 4'b0100; tbl[3] = 4'b0101;
    tbl[4] = 4'b0011; tbl[5] = 4'b0111; tbl[6] = 4'b0001; tbl[7] = 4'b0000;
    if (f3 == 3'd0 && op == 2'b10 && f7[5]) return 4'b0110;
    if (f3 == 3'd5 && f7[5]) return 4'b1000;
    return tbl[f3];
  endfunction

  // Reference: M-op result using full-width arithmetic
  function automatic logic [31:0] modelMd(input logic [2:0] f3,
                                          input logic [31:0] a, b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                   32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int modelLatency(input logic [2:0] f3,
                                      input logic [31:0] a, b);
    if (f3[2] && b == 0) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Drive one instruction into EX just after a rising edge and update the
  // model when it represents a fresh M-op issue or a kill
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic v,
                               input logic fl, input logic [31:0] a, b);
    @(posedge clk);
    #1;
    aluOp = op; funct3 = f3; funct7 = f7; exValid = v; flush = fl;
    opA = a; opB = b;
    if (fl) mdActive = 1'b0;
    else if (v && op == 2'b10 && f7 == 7'b0000001 && !mdActive) begin
      mdActive    = 1'b1;
      mdDoneCycle = cycle + modelLatency(f3, a, b);
      mdExp       = modelMd(f3, a, b);
    end
  endtask

  // Issue an M-op and hold it in EX as a stalled pipeline would
  task automatic issueMop(input logic [2:0] f3, input logic [31:0] a, b,
                          output logic [31:0] res, output int stallCnt,
                          output int doneOff, output int doneCyc);
    applyStimulus(2'b10, f3, 7'b0000001, 1'b1, 1'b0, a, b);
    stallCnt = 0; doneOff = -1; doneCyc = -1; res = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (mdDone) begin
        doneOff = k; doneCyc = cycle; res = mdResult;
        break;
      end
    end
  endtask

  task automatic runVec(input string name, input logic [2:0] f3,
                        input logic [31:0] a, b, exp, input int lat);
    logic [31:0] res;
    int sc, off, dc;
    issueMop(f3, a, b, res, sc, off, dc);
    checkOutput({name, " result"}, res, exp);
    checkOutput({name, " done offset"}, off, lat);
    checkOutput({name, " stall cycles"}, sc, lat);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      expDone  = mdActive && (cycle == mdDoneCycle);
      expStall = exValid && !flush && aluOp == 2'b10 &&
                 funct7 == 7'b0000001 && !expDone;
      checkOutput("ALUSel", {28'b0, aluSel}, {28'b0, modelAluSel(aluOp, funct3, funct7)});
      checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
      checkOutput("done", {31'b0, mdDone}, {31'b0, expDone});
      if (expDone) begin
        checkOutput("model result", mdResult, mdExp);
        mdActive = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] res;
    int sc, off, dc1, dc2, doneCount;

    rst = 1'b1; aluOp = 2'b00; funct3 = 3'b000; funct7 = 7'b0;
    exValid = 1'b0; flush = 1'b0; opA = '0; opB = '0;
    #22 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset result", mdResult, 32'h0);
    checkOutput("reset done", {31'b0, mdDone}, 32'h0);
    checkOutput("reset stall", {31'b0, stall}, 32'h0);

    // Decode sweep over every class, funct3 and both funct7 variants
    for (int op = 0; op < 4; op++)
      for (int alt = 0; alt < 2; alt++)
        for (int f = 0; f < 8; f++)
          applyStimulus(2'(op), 3'(f), alt ? 7'b0100000 : 7'b0000000,
                        1'b1, 1'b0, '0, '0);

    applyStimulus(2'b10, 3'b000, 7'b0100000, 1'b1, 1'b0, '0, '0);
    @(negedge clk) checkOutput("R SUB", {28'b0, aluSel}, 32'h6);
    applyStimulus(2'b11, 3'b000, 7'b0100000, 1'b1, 1'b0, '0, '0);
    @(negedge clk) checkOutput("I ADD", {28'b0, aluSel}, 32'h2);
    applyStimulus(2'b10, 3'b101, 7'b0100000, 1'b1, 1'b0, '0, '0);
    @(negedge clk) checkOutput("R SRA", {28'b0, aluSel}, 32'h8);
    applyStimulus(2'b10, 3'b100, 7'b0000001, 1'b0, 1'b0, 32'd5, 32'd0);
    @(negedge clk) begin
      checkOutput("M-op select", {28'b0, aluSel}, 32'hF);
      checkOutput("invalid M-op stall", {31'b0, stall}, 32'h0);
    end

    // Multiply / divide vectors with hand-computed results
    runVec("MUL",    3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33);
    runVec("MULH",   3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);
    runVec("MULHU",  3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33);
    runVec("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);
    runVec("MULH min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    runVec("MULHU max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    runVec("DIV",    3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
    runVec("REM",    3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
    runVec("DIV negb", 3'd4, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    runVec("REM negb", 3'd6, 32'h7, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    runVec("DIVU",   3'd5, 32'd100, 32'd7, 32'd14, 33);
    runVec("REMU",   3'd7, 32'd100, 32'd7, 32'd2, 33);
    runVec("DIVU by 0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runVec("REM by 0",  3'd6, 32'd5, 32'd0, 32'd5, 1);
    runVec("DIV ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runVec("REM ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Back-to-back M-ops with no bubble between them
    issueMop(3'd0, 32'h1234_5678, 32'h10, res, sc, off, dc1);
    checkOutput("b2b MUL result", res, 32'h2345_6780);
    issueMop(3'd4, 32'hFFFF_FF9C, 32'd10, res, sc, off, dc2);
    checkOutput("b2b DIV result", res, 32'hFFFF_FFF6);
    checkOutput("b2b done spacing", dc2 - dc1, 34);

    // Flush in the tenth CALC cycle
    applyStimulus(2'b10, 3'd0, 7'b0000001, 1'b1, 1'b0, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    applyStimulus(2'b10, 3'd0, 7'b0000001, 1'b1, 1'b1, 32'd3, 32'd5);
    @(negedge clk) checkOutput("flush stall", {31'b0, stall}, 32'h0);
    applyStimulus(2'b00, 3'd0, 7'b0, 1'b0, 1'b0, '0, '0);
    doneCount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mdDone) doneCount++;
    end
    checkOutput("flush no done", doneCount, 0);
    runVec("MUL after flush", 3'd0, 32'd3, 32'd5, 32'd15, 33);

    // Asynchronous reset in the middle of CALC
    applyStimulus(2'b10, 3'd5, 7'b0000001, 1'b1, 1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    mdActive = 1'b0;
    #1;
    checkOutput("async rst result", mdResult, 32'h0);
    checkOutput("async rst done", {31'b0, mdDone}, 32'h0);
    checkOutput("async rst stall", {31'b0, stall}, 32'h0);
    exValid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    runVec("REMU after rst", 3'd7, 32'd100, 32'd7, 32'd2, 33);

    applyStimulus(2'b00, 3'd0, 7'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
